// File: rtl/nibble_packer_432.sv
// Collects 4-bit despreader symbols into 32-bit words, first nibble in bits [3:0].
// Full or flushed partial words sit in a one-word valid/ready output buffer.
module nibble_packer_432 #(
    parameter logic [3:0] PAD_NIBBLE = 4'h0
) (
    input  logic        inClk,
    input  logic        inReset,
    input  logic [3:0]  inNibble,
    input  logic        inNibbleValid,
    output logic        outNibbleReady,
    input  logic        inFlush,
    output logic [31:0] outWord,
    output logic        outWordValid,
    input  logic        inWordReady,
    output logic [3:0]  outNibbleCount,
    output logic [2:0]  outIndex
);

    localparam logic [31:0] PAD_WORD = {8{PAD_NIBBLE}};

    logic [31:0] acc_q, acc_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wvalid_q, wvalid_d;
    logic        fpend_q, fpend_d;

    logic        space;
    logic        accept;
    logic        flush_req;
    logic [3:0]  n_fill;
    logic [31:0] acc_new;
    logic [31:0] padded;

    // A buffer that drains this cycle counts as free, so the 8th nibble never bubbles.
    assign space          = !wvalid_q || inWordReady;
    assign outNibbleReady = !inReset && !fpend_q && ((idx_q != 3'd7) || space);
    assign accept         = inNibbleValid && outNibbleReady;
    assign flush_req      = inFlush || fpend_q;
    assign n_fill         = {1'b0, idx_q} + {3'b000, accept};

    assign outWord        = word_q;
    assign outWordValid   = wvalid_q;
    assign outNibbleCount = cnt_q;
    assign outIndex       = idx_q;

    always_comb begin
        acc_new = acc_q;
        if (accept) acc_new[{idx_q, 2'b00} +: 4] = inNibble;
        padded = PAD_WORD;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < n_fill) padded[k*4 +: 4] = acc_new[k*4 +: 4];
        end
    end

    always_comb begin
        acc_d    = acc_new;
        idx_d    = idx_q + {2'b00, accept};
        word_d   = word_q;
        cnt_d    = cnt_q;
        wvalid_d = wvalid_q && !inWordReady;
        fpend_d  = fpend_q;
        if (n_fill == 4'd8) begin
            // Word complete; any same-cycle flush is absorbed here.
            word_d   = acc_new;
            cnt_d    = 4'd8;
            wvalid_d = 1'b1;
            idx_d    = 3'd0;
            acc_d    = PAD_WORD;
            fpend_d  = 1'b0;
        end else if (flush_req) begin
            if (n_fill == 4'd0) begin
                fpend_d = 1'b0;
            end else if (space) begin
                word_d   = padded;
                cnt_d    = n_fill;
                wvalid_d = 1'b1;
                idx_d    = 3'd0;
                acc_d    = PAD_WORD;
                fpend_d  = 1'b0;
            end else begin
                fpend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge inClk) begin
        if (inReset) begin
            acc_q    <= PAD_WORD;
            idx_q    <= 3'd0;
            word_q   <= 32'h0;
            cnt_q    <= 4'd0;
            wvalid_q <= 1'b0;
            fpend_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            word_q   <= word_d;
            cnt_q    <= cnt_d;
            wvalid_q <= wvalid_d;
            fpend_q  <= fpend_d;
        end
    end

endmodule
